// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: default widths, the controller
// state encoding and the memory bus owner select.
package run_controller_pkg;

  localparam int DEF_WORD_SIZE      = 16;
  localparam int DEF_MEM_ADDR_SIZE  = 16;
  localparam int DEF_CYCLE_CNT_SIZE = 32;
  localparam int DEF_RESET_CYCLES   = 2;

  typedef enum logic [2:0] {
    RC_IDLE    = 3'd0,
    RC_LOAD    = 3'd1,
    RC_CPU_RST = 3'd2,
    RC_RUN     = 3'd3,
    RC_DONE    = 3'd4
  } rc_state_e;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_LOADER = 2'd1,
    BUS_CPU    = 2'd2
  } bus_sel_e;

  // A new load+run may only be started from a quiescent state.
  function automatic logic is_start_state(input rc_state_e state);
    return (state == RC_IDLE) || (state == RC_DONE);
  endfunction

endpackage

// File: rtl/run_controller_mem_bus_mux.sv
// Memory port owner select: loader, cpu, or nobody (bus driven to all-zero).
module run_controller_mem_bus_mux
  import run_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_MEM_ADDR_SIZE,
  parameter int DATA_W = DEF_WORD_SIZE
) (
  input  bus_sel_e          sel,
  input  logic [ADDR_W-1:0] loader_address,
  input  logic [DATA_W-1:0] loader_write_data,
  input  logic              loader_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write
);

  // Combinational 2:1 select, zero when no owner
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (sel)
      BUS_LOADER: begin
        mem_address    = loader_address;
        mem_write_data = loader_write_data;
        mem_write      = loader_write;
      end
      BUS_CPU: begin
        mem_address    = cpu_address;
        mem_write_data = cpu_write_data;
        mem_read       = cpu_read;
        mem_write      = cpu_write;
      end
      default: begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/run_controller.sv
// Sequencer around one cpu and its memory: load a program from the host,
// pulse cpu reset, run until halt or timeout, then report status.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE  = DEF_MEM_ADDR_SIZE,
  parameter int CYCLE_CNT_SIZE = DEF_CYCLE_CNT_SIZE,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      host_start,
  input  logic                      host_load_valid,
  output logic                      host_load_ready,
  input  logic [WORD_SIZE-1:0]      host_load_data,
  input  logic                      host_load_last,
  input  logic [CYCLE_CNT_SIZE-1:0] max_cycles,
  output logic                      cpu_reset,
  output logic                      cpu_execute,
  input  logic                      cpu_halted,
  input  logic [MEM_ADDR_SIZE-1:0]  cpu_mem_address,
  input  logic [WORD_SIZE-1:0]      cpu_mem_write_data,
  input  logic                      cpu_mem_read,
  input  logic                      cpu_mem_write,
  output logic [WORD_SIZE-1:0]      cpu_mem_read_data,
  output logic [MEM_ADDR_SIZE-1:0]  mem_address,
  output logic [WORD_SIZE-1:0]      mem_write_data,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [WORD_SIZE-1:0]      mem_read_data,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [CYCLE_CNT_SIZE-1:0] cycle_count,
  output logic [MEM_ADDR_SIZE-1:0]  words_loaded
);

  localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0]     RST_CNT_LAST = RST_CNT_W'(RESET_CYCLES - 1);
  localparam logic [MEM_ADDR_SIZE-1:0] LOAD_PTR_MAX = '1;

  rc_state_e                 state_r;
  rc_state_e                 next_state_s;
  bus_sel_e                  bus_sel_s;
  logic [MEM_ADDR_SIZE-1:0]  load_ptr_r;
  logic [CYCLE_CNT_SIZE-1:0] cycle_count_r;
  logic [CYCLE_CNT_SIZE-1:0] max_cycles_r;
  logic [CYCLE_CNT_SIZE-1:0] cycle_next_s;
  logic [RST_CNT_W-1:0]      rst_cnt_r;
  logic                      timed_out_r;
  logic                      start_accept_s;
  logic                      load_accept_s;
  logic                      timeout_hit_s;

  assign start_accept_s = host_start && is_start_state(state_r);
  assign load_accept_s  = (state_r == RC_LOAD) && host_load_valid;
  assign cycle_next_s   = cycle_count_r + CYCLE_CNT_SIZE'(1);
  // A saturated counter wraps cycle_next_s to zero, which never matches a non-zero limit.
  assign timeout_hit_s  = (max_cycles_r != '0) && (cycle_next_s == max_cycles_r);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= RC_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RC_IDLE, RC_DONE: begin
        if (host_start) next_state_s = RC_LOAD;
        else            next_state_s = state_r;
      end
      RC_LOAD: begin
        if (load_accept_s && (host_load_last || (load_ptr_r == LOAD_PTR_MAX)))
          next_state_s = RC_CPU_RST;
        else
          next_state_s = RC_LOAD;
      end
      RC_CPU_RST: begin
        if (rst_cnt_r == RST_CNT_LAST) next_state_s = RC_RUN;
        else                           next_state_s = RC_CPU_RST;
      end
      RC_RUN: begin
        if (cpu_halted || timeout_hit_s) next_state_s = RC_DONE;
        else                             next_state_s = RC_RUN;
      end
      default: next_state_s = RC_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    cpu_reset       = 1'b1;
    cpu_execute     = 1'b0;
    host_load_ready = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    bus_sel_s       = BUS_IDLE;
    case (state_r)
      RC_IDLE: cpu_reset = 1'b1;
      RC_LOAD: begin
        host_load_ready = 1'b1;
        busy            = 1'b1;
        bus_sel_s       = BUS_LOADER;
      end
      RC_CPU_RST: busy = 1'b1;
      RC_RUN: begin
        cpu_reset   = 1'b0;
        cpu_execute = 1'b1;
        busy        = 1'b1;
        bus_sel_s   = BUS_CPU;
      end
      RC_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      default: bus_sel_s = BUS_IDLE;
    endcase
  end

  // Load pointer, run counters, timeout capture and reset-hold counter
  always_ff @(posedge clock) begin
    if (reset) begin
      load_ptr_r    <= '0;
      cycle_count_r <= '0;
      max_cycles_r  <= '0;
      timed_out_r   <= 1'b0;
      rst_cnt_r     <= '0;
    end else begin
      if (start_accept_s) begin
        load_ptr_r    <= '0;
        cycle_count_r <= '0;
        timed_out_r   <= 1'b0;
        max_cycles_r  <= max_cycles;
      end else if (load_accept_s) begin
        load_ptr_r <= load_ptr_r + MEM_ADDR_SIZE'(1);
      end else if (state_r == RC_RUN) begin
        if (cycle_count_r != '1) cycle_count_r <= cycle_next_s;
        else                     cycle_count_r <= cycle_count_r;
        // Halt takes priority over a coincident timeout.
        timed_out_r <= !cpu_halted && timeout_hit_s;
      end else begin
        load_ptr_r <= load_ptr_r;
      end
      if (state_r == RC_CPU_RST) rst_cnt_r <= rst_cnt_r + RST_CNT_W'(1);
      else                       rst_cnt_r <= '0;
    end
  end

  run_controller_mem_bus_mux #(
    .ADDR_W(MEM_ADDR_SIZE),
    .DATA_W(WORD_SIZE)
  ) u_mem_bus_mux (
    .sel              (bus_sel_s),
    .loader_address   (load_ptr_r),
    .loader_write_data(host_load_data),
    .loader_write     (load_accept_s),
    .cpu_address      (cpu_mem_address),
    .cpu_write_data   (cpu_mem_write_data),
    .cpu_read         (cpu_mem_read),
    .cpu_write        (cpu_mem_write),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read         (mem_read),
    .mem_write        (mem_write)
  );

  assign cpu_mem_read_data = mem_read_data;
  assign timed_out         = timed_out_r;
  assign cycle_count       = cycle_count_r;
  assign words_loaded      = load_ptr_r;

endmodule
